// File: rtl/mem_pkg.sv
// Shared size codes, FSM state type and size decoding for the RV64 data memory.
// No timing or flow control of its own.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a big-endian 8-byte fetch to the access size and sign/zero extends it.
// Purely combinational; no backpressure.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  output logic [63:0] result
);

  // raw[63:56] is the byte at the access address, so an n-byte value is its top 8n bits
  always_comb begin
    result = raw;
    case (size)
      SZ_B: result = unsigned_load ? {56'd0, raw[63:56]} : {{56{raw[63]}}, raw[63:56]};
      SZ_H: result = unsigned_load ? {48'd0, raw[63:48]} : {{48{raw[63]}}, raw[63:48]};
      SZ_W: result = unsigned_load ? {32'd0, raw[63:32]} : {{32{raw[63]}}, raw[63:32]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with sized loads/stores and an optional clear sweep.
// Loads have one cycle of latency; requests are dropped while busy, rejected ones pulse fault.
module data_memory_sized
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  unsigned_load,
  input  logic [ADDR_WIDTH-1:0] endereco,
  input  logic [63:0]           write_data,
  output logic [63:0]           read_data,
  output logic                  read_valid,
  output logic                  fault,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NBLK  = DEPTH / 8;
  localparam int CW    = (ADDR_WIDTH > 3) ? ADDR_WIDTH - 3 : 1;

  logic [7:0] mem [DEPTH];

  state_t                  state, state_nxt;
  logic [CW-1:0]           clr_cnt;
  logic                    clr_last;
  logic [ADDR_WIDTH-1:0]   clr_addr;

  logic [3:0]              nbytes;
  logic [2:0]              low_mask;
  logic                    misaligned, idle, conflict;
  logic                    store_ok, load_ok, fault_nxt;

  logic [63:0]             raw, ext;
  logic [7:0]              wr_en;
  logic [ADDR_WIDTH-1:0]   wr_base;
  logic [63:0]             wr_word;

  assign clr_last = (clr_cnt == CW'(NBLK - 1));
  assign clr_addr = ADDR_WIDTH'({clr_cnt, 3'b000});
  assign busy     = (state == ST_INIT);
  assign idle     = (state == ST_IDLE);

  assign nbytes     = bytes_of(size);
  assign low_mask   = 3'(nbytes - 4'd1);
  assign misaligned = |(endereco[2:0] & low_mask);
  assign conflict   = mem_read & mem_write;
  assign store_ok   = idle & mem_write & ~misaligned;
  assign load_ok    = idle & mem_read & ~mem_write & ~misaligned;
  assign fault_nxt  = idle & (conflict | ((mem_read | mem_write) & misaligned));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (clr_last) state_nxt = ST_IDLE;
      default: state_nxt = state;
    endcase
  end

  // One 8-byte write port shared by the clear sweep and stores; byte j goes to base+j
  always_comb begin
    wr_en   = '0;
    wr_base = endereco;
    wr_word = '0;
    if (state == ST_INIT) begin
      wr_en   = '1;
      wr_base = clr_addr;
    end else if (store_ok) begin
      wr_word = write_data << {4'd8 - nbytes, 3'b000};
      for (int j = 0; j < 8; j++) wr_en[j] = (4'(j) < nbytes);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 8; j++) begin
        if (wr_en[j]) mem[wr_base + ADDR_WIDTH'(j)] <= wr_word[63-8*j -: 8];
      end
    end
  end

  // Bytes past the access size may wrap; load_extend discards them
  always_comb begin
    raw = '0;
    for (int j = 0; j < 8; j++) raw[63-8*j -: 8] = mem[endereco + ADDR_WIDTH'(j)];
  end

  load_extend u_load_extend (
    .raw           (raw),
    .size          (size),
    .unsigned_load (unsigned_load),
    .result        (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      read_valid <= load_ok;
      fault      <= fault_nxt;
      if (load_ok) read_data <= ext;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized scoreboard bench for data_memory_sized against a byte-array reference model.
module tb_data_memory_sized;

  logic        clk;
  logic        reset;
  logic        mem_read, mem_write, unsigned_load;
  logic [1:0]  size;
  logic [7:0]  endereco;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        read_valid, fault, busy;

  data_memory_sized #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .size          (size),
    .unsigned_load (unsigned_load),
    .endereco      (endereco),
    .write_data    (write_data),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .fault         (fault),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [256];
  logic [63:0] last_rd;
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [1:0] sz, input logic uns, input int a);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[a + i]);
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  // Model the request, queue any expected response, then drive it for one edge
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input int a, input logic [63:0] wd, input bit during_busy);
    int   n;
    bit   mis;
    exp_t e;
    n   = 1 << sz;
    mis = (a % n) != 0;
    if (!during_busy) begin
      if ((rd && wr) || ((rd || wr) && mis)) begin
        e.is_fault = 1'b1;
        e.data     = last_rd;
        exp_q.push_back(e);
      end
      if (wr && !mis) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*(n-1-i) +: 8];
      end
      if (rd && !wr && !mis) begin
        last_rd    = model_load(sz, uns, a);
        e.is_fault = 1'b0;
        e.data     = last_rd;
        exp_q.push_back(e);
      end
    end
    mem_read      = rd;
    mem_write     = wr;
    size          = sz;
    unsigned_load = uns;
    endereco      = 8'(a);
    write_data    = wd;
    @(posedge clk);
    #1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = '0;
  endtask

  // Counts busy cycles after reset release while poking requests that must be ignored
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5)       issue(1'b0, 1'b1, 2'b11, 1'b0, 0, 64'hDEADBEEF_CAFEF00D, 1'b1);
      else if (n == 20) issue(1'b0, 1'b1, 2'b00, 1'b0, 3, 64'h5A, 1'b1);
      else if (n == 21) issue(1'b1, 1'b0, 2'b11, 1'b0, 0, 64'h0, 1'b1);
      else if (n == 22) issue(1'b1, 1'b0, 2'b01, 1'b0, 3, 64'h0, 1'b1);
      else              issue(1'b0, 1'b0, 2'b00, 1'b0, 0, 64'h0, 1'b1);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    last_rd = '0;
  endtask

  always @(negedge clk) begin
    if (read_valid || fault) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: read_valid=%b fault=%b data=%h with nothing expected",
                 read_valid, fault, read_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (fault !== e.is_fault || read_valid !== !e.is_fault || read_data !== e.data) begin
          fails++;
          $display("FAIL response: got fault=%b valid=%b data=%h expected fault=%b valid=%b data=%h",
                   fault, read_valid, read_data, e.is_fault, !e.is_fault, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int a;
    int op;
    logic [1:0] sz;
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; unsigned_load = 1'b0;
    endereco = '0; write_data = '0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_read_data", read_data, 64'd0);
    chk("reset_read_valid", 64'(read_valid), 64'd0);
    chk("reset_fault", 64'(fault), 64'd0);
    chk("reset_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    count_busy(n);
    chk("busy_len_first", 64'(n), 64'd32);

    for (int i = 0; i < 256; i += 8) issue(1'b1, 1'b0, 2'b11, 1'b0, i, 64'h0, 1'b0);

    issue(1'b0, 1'b1, 2'b11, 1'b0, 16, 64'h0123456789ABCDEF, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 16, 64'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 22, 64'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 22, 64'h0, 1'b0);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 4, 64'h80000000, 1'b0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 4, 64'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 0, 64'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 3, 64'h0, 1'b0);
    issue(1'b0, 1'b1, 2'b11, 1'b0, 12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 8, 64'h0, 1'b0);
    issue(1'b1, 1'b1, 2'b11, 1'b0, 8, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 8, 64'h0, 1'b0);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 2, 64'h1234_5678, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 0, 64'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 248, 64'h0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 63) / (1 << sz)) * (1 << sz);
      if ($urandom_range(0, 9) == 0) a = a + 1;
      op = $urandom_range(0, 9);
      issue(op < 4 || op == 8, op >= 4 && op <= 8, sz, 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, 1'b0);
    end
    issue(1'b0, 1'b0, 2'b00, 1'b0, 0, 64'h0, 1'b0);
    @(negedge clk);
    chk("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);

    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) issue(1'b0, 1'b0, 2'b00, 1'b0, 0, 64'h0, 1'b1);
    reset = 1'b1;
    issue(1'b0, 1'b0, 2'b00, 1'b0, 0, 64'h0, 1'b1);
    reset = 1'b0;
    count_busy(n);
    chk("busy_len_restart", 64'(n), 64'd32);
    model_clear();

    for (int i = 0; i < 256; i += 8) issue(1'b1, 1'b0, 2'b11, 1'b0, i, 64'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 3, 64'h0, 1'b0);

    repeat (2) issue(1'b0, 1'b0, 2'b00, 1'b0, 0, 64'h0, 1'b0);
    @(negedge clk);
    chk("queue_drained_final", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
